// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO.
// Defaults for width, depth, pointer width and watermark levels.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH   = 16;
  localparam int FIFO_ADDR_WIDTH   = 7;
  localparam int FIFO_PTR_WIDTH    = FIFO_ADDR_WIDTH + 1;
  localparam int FIFO_ALMOST_FULL  = 120;
  localparam int FIFO_ALMOST_EMPTY = 8;

endpackage

// File: rtl/fifo_memory_array.sv
// Simple dual-port storage: synchronous write, combinational read.
// Contents are not reset.
module fifo_memory_array
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered status flags.
// Define SYNC_FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH         = FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL_LEVEL  = FIFO_ALMOST_FULL,
  parameter int ALMOST_EMPTY_LEVEL = FIFO_ALMOST_EMPTY
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  input  logic                  clear_errors,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(1) << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AF_LVL  = PTR_W'(ALMOST_FULL_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL  = PTR_W'(ALMOST_EMPTY_LEVEL);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [PTR_W-1:0]      w_wr_nxt;
  logic [PTR_W-1:0]      w_rd_nxt;
  logic [PTR_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_wr_acc = write_enable & ~r_full;
  assign w_rd_acc = read_enable & ~r_empty;
  assign w_wr_nxt = r_wr_ptr + PTR_W'(w_wr_acc);
  assign w_rd_nxt = r_rd_ptr + PTR_W'(w_rd_acc);
  // Wrap bit makes the pointer difference the exact occupancy 0..depth
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

  fifo_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (write_data),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_count    <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == DEPTH_C);
      r_empty    <= (w_cnt_nxt == '0);
      r_afull    <= (w_cnt_nxt >= AF_LVL);
      r_aempty   <= (w_cnt_nxt <= AE_LVL);
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_mem_rdata;
      end
    end
  end

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  // A fresh error wins over a same-cycle clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~clear_errors) | (write_enable & r_full);
      r_unf <= (r_unf & ~clear_errors) | (read_enable & r_empty);
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`endif

  assign read_data    = r_rd_data;
  assign read_valid   = r_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign word_count   = r_count;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue scoreboard plus per-scenario tasks.
// Error-flag scenario runs when SYNC_FIFO_ERROR_FLAGS_EN is defined.
module tb_sync_fifo;

  localparam int DEPTH = 128;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        write_enable;
  logic [15:0] write_data;
  logic        read_enable;
  logic [15:0] read_data;
  logic        read_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [7:0]  word_count;
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  logic        clear_errors;
  logic        overflow;
  logic        underflow;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [15:0] q[$];
  int          m_count = 0;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_data = '0;

  sync_fifo dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    .clear_errors (clear_errors),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .word_count   (word_count)
  );

  always #5 clock = ~clock;

  // Scoreboard: compare each read against the word popped at stimulus time
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (read_valid !== exp_valid) begin
        errors++;
        $display("FAIL sb_valid: got %b want %b at %0t",
                 read_valid, exp_valid, $time);
      end
      if (exp_valid) begin
        checks++;
        if (read_data !== exp_data) begin
          errors++;
          $display("FAIL sb_data: got %h want %h at %0t",
                   read_data, exp_data, $time);
        end
      end
    end
    exp_valid = 1'b0;
  end

  task automatic step(input logic we, input logic [15:0] wd,
                      input logic re);
    bit wacc;
    bit racc;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    wacc = we && (m_count < DEPTH);
    racc = re && (m_count > 0);
    @(posedge clock);
    #1;
    if (racc) exp_data = q.pop_front();
    exp_valid = racc;
    if (wacc) q.push_back(wd);
    m_count = m_count + int'(wacc) - int'(racc);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = '0;
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    clear_errors = 1'b0;
`endif
    #12;
    checks++;
    if ({word_count, empty, almost_empty, full, almost_full,
         read_valid, read_data} !== {8'd0, 4'b1100, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset: cnt=%0d e=%b ae=%b f=%b af=%b v=%b d=%h",
               word_count, empty, almost_empty, full, almost_full,
               read_valid, read_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 16'(i + 1), 1'b0);
      checks++;
      if (word_count !== 8'(i + 1) || full !== (i == DEPTH - 1) ||
          empty !== 1'b0 || almost_full !== (i + 1 >= 120) ||
          almost_empty !== (i + 1 <= 8)) begin
        errors++;
        $display("FAIL fill: n=%0d cnt=%0d f=%b af=%b e=%b ae=%b",
                 i + 1, word_count, full, almost_full, empty,
                 almost_empty);
      end
    end
    step(1'b1, 16'hDEAD, 1'b0);
    checks++;
    if (word_count !== 8'd128 || full !== 1'b1) begin
      errors++;
      $display("FAIL overfill: cnt=%0d f=%b want 128/1",
               word_count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 16'h0, 1'b1);
      checks++;
      if (read_valid !== 1'b1 || read_data !== 16'(i + 1) ||
          word_count !== 8'(DEPTH - 1 - i) || full !== 1'b0 ||
          empty !== (i == DEPTH - 1) ||
          almost_empty !== (DEPTH - 1 - i <= 8) ||
          almost_full !== (DEPTH - 1 - i >= 120)) begin
        errors++;
        $display("FAIL drain: i=%0d v=%b d=%h want %h cnt=%0d e=%b ae=%b",
                 i, read_valid, read_data, 16'(i + 1), word_count,
                 empty, almost_empty);
      end
    end
    step(1'b0, 16'h0, 1'b0);
    checks++;
    if (read_valid !== 1'b0 || read_data !== 16'h0080) begin
      errors++;
      $display("FAIL hold: v=%b d=%h want 0/0080", read_valid, read_data);
    end
  endtask

  task automatic test_simul_empty();
    step(1'b1, 16'hA5A5, 1'b1);
    checks++;
    if (read_valid !== 1'b0 || word_count !== 8'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: v=%b cnt=%0d e=%b want 0/1/0",
               read_valid, word_count, empty);
    end
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if (read_valid !== 1'b1 || read_data !== 16'hA5A5 ||
        empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty_rd: v=%b d=%h e=%b want 1/a5a5/1",
               read_valid, read_data, empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 50; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 16'(16'h1000 + i), 1'b1);
      checks++;
      if (word_count !== 8'd50 || read_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap: i=%0d cnt=%0d v=%b want 50/1",
                 i, word_count, read_valid);
      end
    end
    for (int i = 0; i < 50; i++) step(1'b0, 16'h0, 1'b1);
    checks++;
    if (word_count !== 8'd0 || empty !== 1'b1 || q.size() != 0) begin
      errors++;
      $display("FAIL wrap_end: cnt=%0d e=%b q=%0d want 0/1/0",
               word_count, empty, q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 38; i++) step(1'b1, 16'(16'h2000 + i), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({word_count, empty, almost_empty, full, almost_full,
         read_valid, read_data} !== {8'd0, 4'b1100, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_mid: cnt=%0d e=%b ae=%b f=%b af=%b v=%b d=%h",
               word_count, empty, almost_empty, full, almost_full,
               read_valid, read_data);
    end
    q.delete();
    m_count   = 0;
    exp_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if (read_valid !== 1'b1 || read_data !== 16'h1234) begin
      errors++;
      $display("FAIL post_reset: v=%b d=%h want 1/1234",
               read_valid, read_data);
    end
  endtask

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  task automatic test_error_flags();
    step(1'b0, 16'h0, 1'b1);
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow: u=%b o=%b want 1/0", underflow, overflow);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h3000 + i), 1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: o=%b u=%b want 1/1",
               overflow, underflow);
    end
    clear_errors = 1'b1;
    step(1'b1, 16'hBEEF, 1'b0);
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_err: o=%b u=%b want 1/0",
               overflow, underflow);
    end
    step(1'b0, 16'h0, 1'b0);
    clear_errors = 1'b0;
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear: o=%b u=%b want 0/0", overflow, underflow);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul_empty();
    test_back_to_back();
    test_reset_mid();
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    test_error_flags();
`endif
    step(1'b0, 16'h0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO: dual-port storage array, pointer control, occupancy counter and registered status flags in one block. Next-generation replacement for the fixed 16-bit × 128-entry memory used inside the FIFO path. Width, depth and watermark levels are parameters. Handles its own full/empty protection and read-data registration, so producer and consumer logic in the same clock domain connect to it directly.

## Interface
- DATA_WIDTH, 16, bits per word
- ADDR_WIDTH, 7, address bits; depth = 2**ADDR_WIDTH (128)
- ALMOST_FULL_LEVEL, 120, almost_full asserted when word_count >= this value
- ALMOST_EMPTY_LEVEL, 8, almost_empty asserted when word_count <= this value

- clock  input  1  single clock, all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- write_enable  input  1  write request
- write_data  input  DATA_WIDTH  word to store
- read_enable  input  1  read request
- read_data  output  DATA_WIDTH  registered read word
- read_valid  output  1  one-cycle pulse: read_data updated this cycle
- full  output  1  word_count == depth
- empty  output  1  word_count == 0
- almost_full  output  1  watermark flag
- almost_empty  output  1  watermark flag
- word_count  output  ADDR_WIDTH+1  current occupancy, 0..depth
- clear_errors  input  1  clears sticky error flags (SYNC_FIFO_ERROR_FLAGS_EN only)
- overflow  output  1  sticky flag (SYNC_FIFO_ERROR_FLAGS_EN only)
- underflow  output  1  sticky flag (SYNC_FIFO_ERROR_FLAGS_EN only)

## Operation
- Write and read pointers are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address the array. The MSB is a wrap bit. Both pointers increment modulo 2**(ADDR_WIDTH+1).
- Write accepted = write_enable & ~full. The word is stored at wr_ptr[ADDR_WIDTH-1:0] and wr_ptr increments.
- Read accepted = read_enable & ~empty. mem[rd_ptr] is registered into read_data and rd_ptr increments.
- Rejected requests are ignored: no pointer, count or data change.
- Simultaneous accepted write and read: word_count unchanged, both pointers advance.
- Simultaneous requests while full: read accepted, write rejected. full is evaluated from the registered state, not the same-cycle read.
- Simultaneous requests while empty: write accepted, read rejected. No fall-through.
- word_count: +1 on write-only, −1 on read-only, otherwise held.
- full, empty, almost_full and almost_empty are registered. Each is computed from the next-state word_count, so it is coherent with word_count in the same cycle.
- read_data holds its last value when no read is accepted.
- The storage array is not reset; its contents are undefined after power-up.
- Reset values: pointers 0; word_count 0; empty 1; almost_empty 1; full 0; almost_full 0; read_data 0; read_valid 0; overflow 0; underflow 0.
- Reset asserted mid-operation clears all of the above immediately (asynchronous) and discards stored data logically.

## Timing
- Write-to-empty-deassert latency: 1 cycle. empty falls on the edge that accepts the first write.
- Read latency: 1 cycle. read_data and read_valid update on the edge that accepts the read.
- read_valid is high for exactly one cycle per accepted read.
- Back-to-back reads sustain 1 word/cycle. Back-to-back writes sustain 1 word/cycle.
- Release of reset_n is synchronised by the system. The block accepts requests on the first posedge after deassertion.

## Configuration
- SYNC_FIFO_ERROR_FLAGS_EN defined:
  - overflow sets on any cycle with write_enable & full.
  - underflow sets on any cycle with read_enable & empty.
  - Both are sticky until clear_errors is high at a posedge or reset.
  - If clear_errors and a new error occur in the same cycle, the flag remains set.
- SYNC_FIFO_ERROR_FLAGS_EN not defined:
  - overflow, underflow and clear_errors are absent from the port list.
  - Rejected requests are silently dropped.

## Structure
- Shared package fifo_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - default watermark constants;
  - a pointer-width helper constant (ADDR_WIDTH+1).
- One sub-module, fifo_memory_array:
  - simple dual-port array, parametrised DATA_WIDTH/ADDR_WIDTH;
  - synchronous write port with enable;
  - combinational read port.
- sync_fifo registers that read port's output.
- Pointer, count and flag logic lives in sync_fifo.

## Test plan
- Reset, then write 0x0001..0x0080 (128 words) → full=1 after the 128th write, word_count=128, almost_full first asserted at count 120; a 129th write is ignored.
- From full, read 128 words → read_data sequence 0x0001..0x0080, one read_valid pulse each, 1-cycle latency; empty=1 at the end; almost_empty asserted at count 8.
- Simultaneous write/read at count 50 for 300 cycles (pointer wrap) → word_count stays 50; data order preserved across wrap.
- Empty, read_enable and write_enable both high (data 0xA5A5) → write accepted, no read_valid, word_count=1; next cycle read returns 0xA5A5.
- Assert reset_n low while count=37 mid-burst → all outputs immediately at reset values; after release, a write/read of 0x1234 returns 0x1234.
- SYNC_FIFO_ERROR_FLAGS_EN defined: write when full → overflow=1 and stays 1; read when empty → underflow=1; clear_errors pulse → both return to 0.
